branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//   Consumes the ALU Z/N outputs in the EX stage of the pipelined CPU.
//   Holds the architectural condition flags and resolves BRZ/BRN/J.
//   On a taken branch it issues a one-cycle PC redirect and squashes the
//   FLUSH_DEPTH younger instructions with a counted flush.
//   Also counts resolved and taken branches for performance debug.
// PARAMETERS
//   FLUSH_DEPTH  2   cycles of flush after a taken branch (1..15)
//   CNT_W        16  width of the branch statistics counters
// PORTS
//   clk            in   1      rising-edge clock, only clock in the block
//   rst_n          in   1      synchronous reset, active-low
//   ex_valid       in   1      EX-stage instruction valid this cycle
//   flag_we        in   1      instruction writes Z/N (arith/neg/sub ops)
//   alu_z          in   1      ALU zero output
//   alu_n          in   1      ALU negative output (out[31])
//   br_op          in   2      00 none, 01 BRZ, 10 BRN, 11 J
//   br_target      in   32     branch target (register operand xs)
//   z_flag         out  1      registered Z flag
//   n_flag         out  1      registered N flag
//   redirect_valid out  1      one-cycle pulse: load PC from redirect_pc
//   redirect_pc    out  32     registered branch target
//   flush          out  1      squash IF/ID/EX younger instructions
//   br_count       out  CNT_W  resolved branches (br_op != 00), saturating
//   taken_count    out  CNT_W  taken branches, saturating
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): z_flag=0, n_flag=0, redirect_valid=0,
//     redirect_pc=0, flush=0, counters=0, FSM=IDLE, flush counter=0.
//     Reset mid-flush aborts the flush immediately.
//   accept = ex_valid & (state==IDLE); an instruction is ignored otherwise.
//   Flags: on accept & flag_we, z_flag<=alu_z, n_flag<=alu_n at posedge.
//     Else flags hold.
//   Taken (combinational, on accept only):
//     BRZ: z_flag==1; BRN: n_flag==1; J: always; 00: never.
//     Conditions use the REGISTERED flags (the result of the older
//     instruction), never alu_z/alu_n of the same cycle.
//   flag_we with br_op!=00 in one cycle: the flags update, and the branch
//     uses the pre-update flags.
//   FSM states:
//     IDLE  : on accept & taken -> FLUSH; cnt<=FLUSH_DEPTH-1;
//             redirect_valid<=1; redirect_pc<=br_target; flush<=1.
//     FLUSH : redirect_valid<=0; flush stays 1; ex_valid ignored;
//             cnt==0 -> IDLE with flush<=0, else cnt<=cnt-1.
//   Latency: the redirect is seen 1 cycle after the branch is in EX.
//     flush is high for exactly FLUSH_DEPTH consecutive cycles.
//     A new branch is accepted in the first cycle after flush drops.
//   Not-taken branch: no redirect, no flush, stays in IDLE.
//   Counters: on accept & br_op!=00, br_count+1; if taken, taken_count+1.
//     Both saturate at all-ones and never wrap.
//   redirect_pc holds its last value when redirect_valid=0.
// TESTING
//   1 Reset: rst_n=0 for 2 cycles -> all outputs 0, FSM IDLE.
//   2 Flags: flag_we=1, alu_z=1, alu_n=0 -> z_flag=1 next cycle; then
//     BRZ br_target=0x40 -> redirect_valid pulse, redirect_pc=0x40,
//     flush high 2 cycles, taken_count=1.
//   3 Not taken: z=0, n=0, BRN target 0x80 -> no redirect, flush=0,
//     br_count+1, taken_count unchanged.
//   4 Same-cycle hazard: z_flag=0, BRZ with flag_we=1, alu_z=1 -> not
//     taken; z_flag=1 afterwards.
//   5 Squash: J to 0x10, then ex_valid=1, flag_we=1, alu_n=1 during
//     flush -> n_flag unchanged, no second redirect. Drop rst_n in flush
//     cycle 1 -> flush=0 the next cycle.
//   6 Saturation (CNT_W=4): 20 taken J -> br_count=taken_count=4'hF.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: holds Z/N flags, resolves BRZ/BRN/J, redirects PC and squashes younger instructions.
// Redirect one cycle after the branch is in EX; flush lasts FLUSH_DEPTH cycles, during which ex_valid is ignored.
module branch_resolve_unit #(
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             flag_we,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic [1:0]       br_op,
    input  logic [31:0]      br_target,
    output logic             z_flag,
    output logic             n_flag,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_BRZ  = 2'b01;
    localparam logic [1:0] OP_BRN  = 2'b10;
    localparam logic [1:0] OP_J    = 2'b11;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic             r_z, r_n, r_redirect, r_flush;
    logic             w_redirect_nxt, w_flush_nxt;
    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_br_count, r_taken_count;
    logic             w_accept, w_taken;

    assign w_accept = ex_valid && (r_state == IDLE);

    // Conditions read the registered flags, i.e. the older instruction's result.
    always_comb begin
        w_taken = 1'b0;
        if (w_accept) begin
            case (br_op)
                OP_BRZ:  w_taken = r_z;
                OP_BRN:  w_taken = r_n;
                OP_J:    w_taken = 1'b1;
                default: w_taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_redirect_nxt = 1'b0;
        w_flush_nxt    = r_flush;
        case (r_state)
            IDLE: begin
                w_flush_nxt = 1'b0;
                if (w_taken) begin
                    w_state_nxt    = FLUSH;
                    w_cnt_nxt      = 4'(FLUSH_DEPTH - 1);
                    w_redirect_nxt = 1'b1;
                    w_flush_nxt    = 1'b1;
                end
            end
            FLUSH: begin
                w_flush_nxt = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = IDLE;
                    w_flush_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_flush_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= 4'd0;
            r_z           <= 1'b0;
            r_n           <= 1'b0;
            r_redirect    <= 1'b0;
            r_flush       <= 1'b0;
            r_pc          <= 32'd0;
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_redirect <= w_redirect_nxt;
            r_flush    <= w_flush_nxt;
            if (w_accept && flag_we) begin
                r_z <= alu_z;
                r_n <= alu_n;
            end
            if (w_taken) begin
                r_pc <= br_target;
            end
            // Statistics saturate instead of wrapping.
            if (w_accept && (br_op != OP_NONE) && (r_br_count != '1)) begin
                r_br_count <= r_br_count + CNT_W'(1);
            end
            if (w_taken && (r_taken_count != '1)) begin
                r_taken_count <= r_taken_count + CNT_W'(1);
            end
        end
    end

    assign z_flag         = r_z;
    assign n_flag         = r_n;
    assign redirect_valid = r_redirect;
    assign redirect_pc    = r_pc;
    assign flush          = r_flush;
    assign br_count       = r_br_count;
    assign taken_count    = r_taken_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized traffic against a cycle model.
module tb_branch_resolve_unit;

    localparam int FD    = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, ex_valid, flag_we, alu_z, alu_n;
    logic [1:0]    br_op;
    logic [31:0]   br_target;
    logic          z_flag, n_flag, redirect_valid, flush;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] br_count, taken_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: architectural view, flush expressed as cycles remaining.
    logic        m_z, m_n, m_redir;
    logic [31:0] m_pc;
    int          m_br, m_tk, m_flush_left;

    branch_resolve_unit #(.FLUSH_DEPTH(FD), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .flag_we(flag_we),
        .alu_z(alu_z), .alu_n(alu_n), .br_op(br_op), .br_target(br_target),
        .z_flag(z_flag), .n_flag(n_flag), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .br_count(br_count),
        .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic v, input logic we, input logic z,
                        input logic n, input logic [1:0] op, input logic [31:0] tgt);
        logic acc, tk;
        rst_n = rst; ex_valid = v; flag_we = we; alu_z = z; alu_n = n;
        br_op = op; br_target = tgt;
        @(posedge clk);
        if (!rst) begin
            m_z = 0; m_n = 0; m_redir = 0; m_pc = 0; m_br = 0; m_tk = 0; m_flush_left = 0;
        end else begin
            acc = v && (m_flush_left == 0);
            if (m_flush_left > 0) m_flush_left--;
            m_redir = 0;
            if (acc) begin
                tk = (op == 2'b11) || (op == 2'b01 && m_z) || (op == 2'b10 && m_n);
                if (op != 2'b00 && m_br < CMAX) m_br++;
                if (tk) begin
                    if (m_tk < CMAX) m_tk++;
                    m_redir = 1;
                    m_pc = tgt;
                    m_flush_left = FD;
                end
                if (we) begin m_z = z; m_n = n; end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 2'b00, 32'd0);
        step(0, 0, 0, 0, 0, 2'b00, 32'd0);
    endtask

    task automatic test_reset();
        step(0, 1, 1, 1, 1, 2'b11, 32'hDEAD_BEEF);
        step(0, 1, 1, 1, 1, 2'b11, 32'hDEAD_BEEF);
        n_checks++;
        if ({z_flag, n_flag, redirect_valid, flush} !== 4'b0000 || redirect_pc !== 32'd0
            || br_count !== 4'd0 || taken_count !== 4'd0) begin
            n_errors++;
            $display("FAIL reset: z=%b n=%b rv=%b fl=%b pc=%h br=%0d tk=%0d, required all zero",
                     z_flag, n_flag, redirect_valid, flush, redirect_pc, br_count, taken_count);
        end
    endtask

    task automatic test_flags_brz();
        do_reset();
        step(1, 1, 1, 1, 0, 2'b00, 32'd0);
        n_checks++;
        if (z_flag !== 1'b1 || n_flag !== 1'b0) begin
            n_errors++; $display("FAIL flag_write: z=%b n=%b, required z=1 n=0", z_flag, n_flag);
        end
        step(1, 1, 0, 0, 0, 2'b01, 32'h40);
        n_checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h40 || flush !== 1'b1) begin
            n_errors++; $display("FAIL brz_taken: rv=%b pc=%h fl=%b, required 1 00000040 1",
                                 redirect_valid, redirect_pc, flush);
        end
        n_checks++;
        if (taken_count !== 4'd1 || br_count !== 4'd1) begin
            n_errors++; $display("FAIL brz_counts: br=%0d tk=%0d, required 1 1", br_count, taken_count);
        end
        step(1, 0, 0, 0, 0, 2'b00, 32'd0);
        n_checks++;
        if (redirect_valid !== 1'b0 || flush !== 1'b1 || redirect_pc !== 32'h40) begin
            n_errors++; $display("FAIL flush_cycle2: rv=%b fl=%b pc=%h, required 0 1 00000040",
                                 redirect_valid, flush, redirect_pc);
        end
        step(1, 0, 0, 0, 0, 2'b00, 32'd0);
        n_checks++;
        if (flush !== 1'b0) begin
            n_errors++; $display("FAIL flush_end: fl=%b, required 0", flush);
        end
        // First cycle after flush drops must accept a new branch.
        step(1, 1, 0, 0, 0, 2'b11, 32'h44);
        n_checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h44) begin
            n_errors++; $display("FAIL accept_after_flush: rv=%b pc=%h, required 1 00000044",
                                 redirect_valid, redirect_pc);
        end
    endtask

    task automatic test_not_taken();
        do_reset();
        step(1, 1, 1, 0, 0, 2'b00, 32'd0);
        step(1, 1, 0, 0, 0, 2'b10, 32'h80);
        n_checks++;
        if (redirect_valid !== 1'b0 || flush !== 1'b0) begin
            n_errors++; $display("FAIL brn_not_taken: rv=%b fl=%b, required 0 0", redirect_valid, flush);
        end
        n_checks++;
        if (br_count !== 4'd1 || taken_count !== 4'd0) begin
            n_errors++; $display("FAIL not_taken_counts: br=%0d tk=%0d, required 1 0", br_count, taken_count);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        step(1, 1, 1, 1, 0, 2'b01, 32'h100);
        n_checks++;
        if (redirect_valid !== 1'b0 || flush !== 1'b0 || z_flag !== 1'b1) begin
            n_errors++; $display("FAIL same_cycle_hazard: rv=%b fl=%b z=%b, required 0 0 1",
                                 redirect_valid, flush, z_flag);
        end
    endtask

    task automatic test_squash();
        do_reset();
        step(1, 1, 0, 0, 0, 2'b11, 32'h10);
        step(1, 1, 1, 0, 1, 2'b11, 32'h99);
        n_checks++;
        if (n_flag !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h10 || br_count !== 4'd1) begin
            n_errors++; $display("FAIL squash: n=%b rv=%b pc=%h br=%0d, required 0 0 00000010 1",
                                 n_flag, redirect_valid, redirect_pc, br_count);
        end
        do_reset();
        step(1, 1, 0, 0, 0, 2'b11, 32'h10);
        step(0, 0, 0, 0, 0, 2'b00, 32'd0);
        n_checks++;
        if (flush !== 1'b0 || redirect_pc !== 32'd0) begin
            n_errors++; $display("FAIL reset_mid_flush: fl=%b pc=%h, required 0 00000000", flush, redirect_pc);
        end
        step(1, 1, 0, 0, 0, 2'b11, 32'h20);
        n_checks++;
        if (redirect_valid !== 1'b1) begin
            n_errors++; $display("FAIL accept_after_abort: rv=%b, required 1", redirect_valid);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0, 0, 2'b11, 32'(i));
            step(1, 0, 0, 0, 0, 2'b00, 32'd0);
            step(1, 0, 0, 0, 0, 2'b00, 32'd0);
        end
        n_checks++;
        if (br_count !== 4'hF || taken_count !== 4'hF) begin
            n_errors++; $display("FAIL saturation: br=%h tk=%h, required f f", br_count, taken_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom), 1'($urandom), 2'($urandom), $urandom);
            n_checks++;
            if (z_flag !== m_z || n_flag !== m_n) begin
                n_errors++; $display("FAIL rand_flags cyc %0d: z=%b n=%b, required %b %b", i, z_flag, n_flag, m_z, m_n);
            end
            n_checks++;
            if (redirect_valid !== m_redir || redirect_pc !== m_pc) begin
                n_errors++; $display("FAIL rand_redirect cyc %0d: rv=%b pc=%h, required %b %h",
                                     i, redirect_valid, redirect_pc, m_redir, m_pc);
            end
            n_checks++;
            if (flush !== (m_flush_left > 0)) begin
                n_errors++; $display("FAIL rand_flush cyc %0d: fl=%b, required %b", i, flush, (m_flush_left > 0));
            end
            n_checks++;
            if (int'(br_count) != m_br || int'(taken_count) != m_tk) begin
                n_errors++; $display("FAIL rand_counts cyc %0d: br=%0d tk=%0d, required %0d %0d",
                                     i, br_count, taken_count, m_br, m_tk);
            end
        end
    endtask

    initial begin
        rst_n = 0; ex_valid = 0; flag_we = 0; alu_z = 0; alu_n = 0; br_op = 2'b00; br_target = 32'd0;
        m_z = 0; m_n = 0; m_redir = 0; m_pc = 0; m_br = 0; m_tk = 0; m_flush_left = 0;
        test_reset();
        test_flags_brz();
        test_not_taken();
        test_hazard();
        test_squash();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
